// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, round-robin pick,
// single request/service handshake with the core controller.
module irq_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               irq_taken,
    input  logic               ret_from_irq,
    input  logic               flush_full,
    input  logic               overrun_clr,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun,
    output logic [1:0]         state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] src_q;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] claim;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      idx;
    logic               found;
    logic [ID_W-1:0]    rr_next;

    assign rise = irq_src & ~src_q;
    assign cand = pending & irq_en;

    always_comb begin
        claim = '0;
        if (state == REQ && !flush_full && irq_en[irq_id] && irq_taken)
            claim = NUM_SRC'(1) << irq_id;
    end

    // Search upward from rr_ptr, wrapping at NUM_SRC (need not be 2^ID_W).
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_SRC))
                idx = idx - (ID_W+1)'(NUM_SRC);
            if (!found && cand[idx[ID_W-1:0]]) begin
                win   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign rr_next = (irq_id == ID_W'(NUM_SRC-1)) ? '0 : irq_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= '0;
            pending <= '0;
            overrun <= '0;
            rr_ptr  <= '0;
            irq_id  <= '0;
        end else begin
            src_q   <= irq_src;
            // A new edge beats a same-cycle claim or clear.
            pending <= (pending & ~claim) | rise;
            overrun <= (overrun_clr ? '0 : overrun) | (rise & pending);
            unique case (state)
                IDLE: begin
                    if (|cand) begin
                        irq_id <= win;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (flush_full)
                        state <= IDLE;
                    else if (!irq_en[irq_id])
                        state <= IDLE;
                    else if (irq_taken)
                        state <= SERVICE;
                end
                SERVICE: begin
                    if (flush_full) begin
                        state <= IDLE;
                    end else if (ret_from_irq) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq        = (state == REQ);
    assign in_service = (state == SERVICE);
    assign state_out  = state;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: capture, round-robin, masking,
// overrun, flush priority and mid-service reset.
module tb_irq_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] irq_src;
    logic [7:0] irq_en;
    logic       irq_taken;
    logic       ret_from_irq;
    logic       flush_full;
    logic       overrun_clr;
    logic       irq;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic [1:0] state_out;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_src      (irq_src),
        .irq_en       (irq_en),
        .irq_taken    (irq_taken),
        .ret_from_irq (ret_from_irq),
        .flush_full   (flush_full),
        .overrun_clr  (overrun_clr),
        .irq          (irq),
        .irq_id       (irq_id),
        .in_service   (in_service),
        .pending      (pending),
        .overrun      (overrun),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter in REQ with exp_id; leave in IDLE right after the return.
    task automatic serve(input string tag, input logic [2:0] exp_id);
        chk({tag, "_irq"}, 32'(irq), 32'd1);
        chk({tag, "_id"}, 32'(irq_id), 32'(exp_id));
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        chk({tag, "_svc"}, 32'(in_service), 32'd1);
        ret_from_irq = 1'b1;
        step();
        ret_from_irq = 1'b0;
        chk({tag, "_ret"}, 32'(state_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        irq_src = '0;
        irq_en = 8'hFF;
        irq_taken = 1'b0;
        ret_from_irq = 1'b0;
        flush_full = 1'b0;
        overrun_clr = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        rst = 1'b0;

        // single source 3
        irq_src = 8'h08;
        step();
        chk("s3_pend", 32'(pending), 32'h08);
        chk("s3_noirq", 32'(irq), 32'd0);
        irq_src = '0;
        step();
        chk("s3_irq", 32'(irq), 32'd1);
        chk("s3_id", 32'(irq_id), 32'd3);
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        chk("s3_claim", 32'(pending), 32'h00);
        chk("s3_svc", 32'(in_service), 32'd1);
        chk("s3_irqlow", 32'(irq), 32'd0);
        step();
        chk("s3_hold", 32'(in_service), 32'd1);
        ret_from_irq = 1'b1;
        step();
        ret_from_irq = 1'b0;
        chk("s3_idle", 32'(state_out), 32'd0);

        // rr_ptr is now 4: of {2,5} source 5 wins first
        irq_src = 8'h24;
        step();
        irq_src = '0;
        step();
        serve("rr4a", 3'd5);
        step();
        serve("rr4b", 3'd2);

        // round-robin after reset: 1,5,6 then 1,6 with rr_ptr = 7
        rst = 1'b1;
        step();
        rst = 1'b0;
        irq_src = 8'h62;
        step();
        chk("rr_pend", 32'(pending), 32'h62);
        irq_src = '0;
        step();
        serve("rr1", 3'd1);
        step();
        serve("rr5", 3'd5);
        step();
        serve("rr6", 3'd6);
        irq_src = 8'h42;
        step();
        irq_src = '0;
        step();
        serve("rr7_1", 3'd1);
        step();
        serve("rr7_6", 3'd6);

        // mask and withdraw
        irq_src = 8'h04;
        step();
        irq_src = '0;
        step();
        chk("msk_id", 32'(irq_id), 32'd2);
        irq_en = 8'hFB;
        step();
        chk("msk_drop", 32'(irq), 32'd0);
        chk("msk_pend", 32'(pending), 32'h04);
        step();
        chk("msk_idle", 32'(state_out), 32'd0);
        irq_en = 8'hFF;
        step();
        serve("msk_re", 3'd2);

        // overrun and same-cycle set vs claim
        irq_src = 8'h01;
        step();
        irq_src = '0;
        step();
        chk("ovr_req", 32'(irq_id), 32'd0);
        irq_src = 8'h01;
        step();
        chk("ovr_set", 32'(overrun), 32'h01);
        irq_src = '0;
        step();
        irq_src = 8'h01;
        irq_taken = 1'b1;
        step();
        irq_src = '0;
        irq_taken = 1'b0;
        chk("ovr_keep", 32'(pending), 32'h01);
        chk("ovr_svc", 32'(in_service), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h00);
        ret_from_irq = 1'b1;
        step();
        ret_from_irq = 1'b0;
        step();
        chk("ovr_rereq", 32'(irq), 32'd1);

        // flush beats irq_taken in REQ
        flush_full = 1'b1;
        irq_taken = 1'b1;
        step();
        flush_full = 1'b0;
        irq_taken = 1'b0;
        chk("fl_req_st", 32'(state_out), 32'd0);
        chk("fl_req_pend", 32'(pending), 32'h01);
        step();
        serve("fl_re0", 3'd0);

        // flush beats ret_from_irq in SERVICE: rr_ptr stays 1
        irq_src = 8'h10;
        step();
        irq_src = '0;
        step();
        chk("fl_id4", 32'(irq_id), 32'd4);
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        irq_src = 8'h09;
        step();
        irq_src = '0;
        flush_full = 1'b1;
        ret_from_irq = 1'b1;
        step();
        flush_full = 1'b0;
        ret_from_irq = 1'b0;
        chk("fl_svc_st", 32'(state_out), 32'd0);
        chk("fl_svc_pend", 32'(pending), 32'h09);
        step();
        chk("fl_rr_id", 32'(irq_id), 32'd3);

        // reset in the middle of a service
        irq_taken = 1'b1;
        step();
        irq_taken = 1'b0;
        chk("mr_svc", 32'(in_service), 32'd1);
        irq_src = 8'h01;
        step();
        chk("mr_ovr", 32'(overrun), 32'h01);
        rst = 1'b1;
        step();
        chk("mr_state", 32'(state_out), 32'd0);
        chk("mr_irq", 32'(irq), 32'd0);
        chk("mr_svc0", 32'(in_service), 32'd0);
        chk("mr_pend", 32'(pending), 32'h00);
        chk("mr_ovr0", 32'(overrun), 32'h00);
        chk("mr_id", 32'(irq_id), 32'd0);
        rst = 1'b0;
        step();
        chk("mr_edge", 32'(pending), 32'h01);
        step();
        step();
        serve("mr_req", 3'd0);
        step();
        chk("mr_once", 32'(irq), 32'd0);
        chk("mr_once_p", 32'(pending), 32'h00);
        irq_src = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

- Collects interrupt requests from up to NUM_SRC peripheral lines.
- Latches rising edges into per-source pending bits and masks them with per-source enables.
- Picks one winner by round-robin and presents a single `irq` request with its ID to the core controller FSM.
- Tracks the in-service interrupt through to `ret_from_irq`; no nesting: one interrupt is in service at a time, and new edges stay pending.

## Interface
- NUM_SRC, 8: number of interrupt sources (2..32).
- ID_W, 3: width of the source ID; must equal clog2(NUM_SRC).

- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  raw level lines from peripherals; a rising edge raises a request.
- irq_en  in  NUM_SRC  per-source enable mask.
- irq_taken  in  1  controller has accepted the request (it has left PROGRAM for the partial-flush state).
- ret_from_irq  in  1  handler return executed.
- flush_full  in  1  controller full flush / soft reset; aborts any request or service.
- overrun_clr  in  1  clears all overrun flags.
- irq  out  1  request to the controller.
- irq_id  out  ID_W  winning source; valid while `irq` or `in_service` is high.
- in_service  out  1  handler for `irq_id` is running.
- pending  out  NUM_SRC  latched, unserviced edges.
- overrun  out  NUM_SRC  sticky: an edge arrived while the same source was already pending.
- state_out  out  2  debug: 0 = IDLE, 1 = REQ, 2 = SERVICE.

## Operation
**Edge capture**
- `src_q` is a registered copy of `irq_src`; `edge = irq_src & ~src_q`.
- `src_q` resets to 0, so a line held high through reset counts as one edge on the first cycle after reset.
- `pending[i]` is set by `edge[i]` and cleared only by a claim of source i.
- If `edge[i]` and a claim of i occur in the same cycle, the set wins and `pending[i]` stays 1.
- If `edge[i]` arrives while `pending[i]` is already 1, `overrun[i]` is set.
- `overrun_clr` clears all overrun bits; a new overrun event in the same cycle wins.

**Arbitration**
- `cand = pending & irq_en`.
- The winner is the first set bit of `cand` searching upward from `rr_ptr`, wrapping from NUM_SRC-1 to 0.
- `rr_ptr` resets to 0. After each `ret_from_irq` it becomes (served id + 1) mod NUM_SRC.

**FSM**
- IDLE
  - If `cand` is non-zero: register the winner into `irq_id` and go to REQ.
- REQ (`irq` = 1)
  - `flush_full` has priority: go to IDLE; pending is kept.
  - Else if `irq_en[irq_id]` has dropped: go to IDLE, withdrawing the request; pending is kept.
  - Else if `irq_taken`: clear `pending[irq_id]` (this is the claim) and go to SERVICE.
- SERVICE (`in_service` = 1)
  - If `flush_full`: go to IDLE; `rr_ptr` is not updated.
  - Else if `ret_from_irq`: update `rr_ptr` and go to IDLE.
  - Edges arriving during SERVICE only set pending (and overrun where applicable).
- `irq_taken` or `ret_from_irq` arriving in any other state is ignored.

**Reset**
- `rst` forces IDLE and clears pending, overrun, `src_q`, `rr_ptr` and `irq_id`.
- All outputs read 0 on the cycle after `rst` is sampled high, including during any operation in progress.

## Timing
**Latency**
- `irq_src[i]` rises, first sampled at edge t0: `pending[i]` = 1 after t0.
- `irq_id` is registered and `irq` = 1 after t1.
- Minimum latency from line to `irq` is 2 cycles.

**Decodes**
- `irq`, `in_service` and `state_out` are combinational decodes of the state register; there is no combinational path from any input to any output.

**Handshake**
- `irq` is held high with a stable `irq_id` until `irq_taken`, `flush_full` or an enable drop.
- The claim and the transition to SERVICE happen on the edge where `irq_taken` is sampled.
- `irq` falls on that same edge.

**Re-request**
- After `ret_from_irq`, the state is IDLE for at least one cycle.
- The next `irq` can rise no earlier than 2 cycles after `ret_from_irq` is sampled.

**Simultaneous events**
- In REQ, when `flush_full` and `irq_taken` are sampled together, `flush_full` wins and there is no claim.
- In SERVICE, when `flush_full` and `ret_from_irq` are sampled together, `flush_full` wins and `rr_ptr` is unchanged.

## Test plan
- Single source: pulse `irq_src[3]` → `pending` = 0x08; `irq` = 1 with `irq_id` = 3 two cycles later. Then `irq_taken` → `pending` = 0, `in_service` = 1. Then `ret_from_irq` → IDLE, `rr_ptr` = 4.
- Round-robin fairness: after reset, raise sources 1, 5 and 6 in the same cycle and serve each. Grant order must be 1, 5, 6. Re-raise 1 and 6, with `rr_ptr` = 7 → order 1, then 6.
- Mask and withdraw: while REQ with `irq_id` = 2, drop `irq_en[2]` → `irq` falls next cycle and `pending[2]` stays 1. Re-enable it → request reissued with `irq_id` = 2.
- Overrun and same-cycle set: re-pulse `irq_src[0]` while `pending[0]` = 1 → `overrun[0]` = 1. A fresh edge on source 0 in the `irq_taken` cycle → `pending[0]` remains 1.
- Flush priority: assert `flush_full` together with `irq_taken` in REQ → IDLE, no claim. Assert `flush_full` together with `ret_from_irq` in SERVICE → IDLE, `rr_ptr` unchanged.
- Mid-operation reset: pulse `rst` during SERVICE → next cycle state 0 and `irq` = `in_service` = `pending` = `overrun` = 0. A line held high through reset yields one new request afterwards.
